// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// -------------------
// CPU register file (NREGS x DWIDTH) with two combinational read ports, one
// synchronous write-back port and a per-register busy scoreboard that holds
// decode when a consumed source operand still has a write in flight.
//
// Ports:
//   clk                  system clock, all state updates on the rising edge
//   rst                  synchronous active-high reset (clears regs and busy bits)
//   rd_addr0/rd_addr1    read indices (rs / rt)
//   rd_data0/rd_data1    combinational read data, with write-through bypass
//   wr_en/wr_addr/wr_data  write-back strobe, destination and data
//   issue_en/issue_addr  instruction issue strobe and its destination index
//   rd_use0/rd_use1      the issuing instruction really consumes port 0 / 1
//   stall                combinational: a consumed source is still busy
//   busy_vec             registered per-register busy bits (bit 0 always 0)

module reg_file_scoreboard #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int NREGS  = 2**AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] rd_addr0,
  input  logic [AWIDTH-1:0] rd_addr1,
  output logic [DWIDTH-1:0] rd_data0,
  output logic [DWIDTH-1:0] rd_data1,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              issue_en,
  input  logic [AWIDTH-1:0] issue_addr,
  input  logic              rd_use0,
  input  logic              rd_use1,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // One-hot decodes of the write-back and issue destinations. Index 0 is
  // masked here so register 0 can never be written or marked busy.
  logic [NREGS-1:0]  wr_onehot;
  logic [NREGS-1:0]  issue_onehot;

  logic              byp0;
  logic              byp1;
  logic              stall0;
  logic              stall1;

  // Decode destination indices into one-hot enables, zero entry masked off.
  always_comb begin
    wr_onehot    = '0;
    issue_onehot = '0;
    if (wr_en) begin
      wr_onehot[wr_addr] = 1'b1;
    end
    if (issue_en) begin
      issue_onehot[issue_addr] = 1'b1;
    end
    wr_onehot[0]    = 1'b0;
    issue_onehot[0] = 1'b0;
  end

  // Next-state for storage and scoreboard. A new issue to a register wins
  // over a write-back retiring the same register in the same cycle: the
  // older producer's data is stored but the younger one is still pending.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_onehot[i]) begin
        regs_d[i] = wr_data;
      end
      if (issue_onehot[i]) begin
        busy_d[i] = 1'b1;
      end else if (wr_onehot[i]) begin
        busy_d[i] = 1'b0;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers; reset overrides any concurrent write or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. A write-back to the same non-zero index is forwarded so
  // decode sees the value in the cycle it is being written.
  always_comb begin
    byp0 = wr_en && (wr_addr == rd_addr0) && (rd_addr0 != '0);
    byp1 = wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0);

    if (rd_addr0 == '0) begin
      rd_data0 = '0;
    end else if (byp0) begin
      rd_data0 = wr_data;
    end else begin
      rd_data0 = regs_q[rd_addr0];
    end

    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else if (byp1) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_q[rd_addr1];
    end
  end

  // Stall when a consumed source is busy and not being retired right now;
  // a retiring register is covered by the bypass above.
  always_comb begin
    stall0 = rd_use0 && (rd_addr0 != '0) && busy_q[rd_addr0] && !byp0;
    stall1 = rd_use1 && (rd_addr1 != '0) && busy_q[rd_addr1] && !byp1;
    stall  = stall0 || stall1;
  end

  assign busy_vec = busy_q;

endmodule
